// File: rtl/ram_io_responder_if.sv
// Bus and host-side signal bundle for the RAM/IO responder.
// The master side is the memory controller plus host; the slave side is the responder.
interface ram_io_responder_if;
   logic        RWstate;
   logic [31:0] RWaddr;
   logic [7:0]  WrtData;
   logic [7:0]  ReadData;
   logic        ioInEn;
   logic [7:0]  ioInData;
   logic        ioInFull;
   logic        ioOutValid;
   logic [7:0]  ioOutData;
   logic        ioOutReady;

   modport master (
      output RWstate, RWaddr, WrtData, ioInEn, ioInData, ioOutReady,
      input  ReadData, ioInFull, ioOutValid, ioOutData
   );

   modport slave (
      input  RWstate, RWaddr, WrtData, ioInEn, ioInData, ioOutReady,
      output ReadData, ioInFull, ioOutValid, ioOutData
   );
endinterface

// File: rtl/ram_io_responder.sv
// Byte-wide RAM responder with a memory-mapped I/O window at 0x30000 holding
// an input FIFO (host -> bus) and an output FIFO (bus -> host).
module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8
) (
   input logic              clk,
   input logic              rst,
   input logic              rdy,
   ram_io_responder_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [17:0] IO_DATA_ADDR = 18'h30000;
   localparam logic [17:0] IO_STAT_ADDR = 18'h30004;

   logic [7:0] mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] ramIdx;

   logic [7:0]       readData_q;
   logic [7:0]       inBuf_q  [FIFO_DEPTH];
   logic [7:0]       outBuf_q [FIFO_DEPTH];
   logic [PTR_W-1:0] inHead_q, inHead_d, inTail_q, inTail_d;
   logic [PTR_W-1:0] outHead_q, outHead_d, outTail_q, outTail_d;
   logic [CNT_W-1:0] inCount_q, inCount_d, outCount_q, outCount_d;
   logic             overflow_q, overflow_d;

   logic busRead, busWrite, ioRegion, dataSel, statSel, ramWrite;
   logic inFull, inNonEmpty, outFull, outValid;
   logic inPush, inPop, hostPop, outWrite, outPush, overflowSet, overflowClr;
   logic [7:0] statusByte, ioReadByte;
   logic unusedAddrBits;

   assign unusedAddrBits = ^bus.RWaddr[31:18];

   assign busRead  = rdy & ~bus.RWstate;
   assign busWrite = rdy & bus.RWstate;
   assign ioRegion = (bus.RWaddr[17:16] == 2'b11);
   assign dataSel  = (bus.RWaddr[17:0] == IO_DATA_ADDR);
   assign statSel  = (bus.RWaddr[17:0] == IO_STAT_ADDR);
   assign ramIdx   = bus.RWaddr[ADDR_WIDTH-1:0];
   assign ramWrite = busWrite & ~ioRegion & ~rst;

   assign inFull     = (inCount_q == FULL_CNT);
   assign inNonEmpty = (inCount_q != '0);
   assign outFull    = (outCount_q == FULL_CNT);
   assign outValid   = (outCount_q != '0);

   assign inPush      = rdy & bus.ioInEn & ~inFull;
   assign inPop       = busRead & dataSel & inNonEmpty;
   assign hostPop     = rdy & outValid & bus.ioOutReady;
   assign outWrite    = busWrite & dataSel;
   // A full output FIFO still accepts a bus byte when the host frees a slot this cycle.
   assign outPush     = outWrite & (~outFull | hostPop);
   assign overflowSet = outWrite & outFull & ~hostPop;
   assign overflowClr = busWrite & statSel;

   assign statusByte = {5'b0, overflow_q, outFull, inNonEmpty};

   always_comb begin
      ioReadByte = 8'h00;
      if (dataSel) begin
         ioReadByte = inNonEmpty ? inBuf_q[inHead_q] : 8'h00;
      end else if (statSel) begin
         ioReadByte = statusByte;
      end
   end

   // RAM contents survive reset so simulation preloads are kept.
   always_ff @(posedge clk) begin
      if (ramWrite) begin
         mem[ramIdx] <= bus.WrtData;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         readData_q <= 8'h00;
      end else if (busRead) begin
         readData_q <= ioRegion ? ioReadByte : mem[ramIdx];
      end
   end

   always_ff @(posedge clk) begin
      if (inPush) begin
         inBuf_q[inTail_q] <= bus.ioInData;
      end
      if (outPush) begin
         outBuf_q[outTail_q] <= bus.WrtData;
      end
   end

   always_comb begin
      inHead_d   = inHead_q;
      inTail_d   = inTail_q;
      inCount_d  = inCount_q;
      outHead_d  = outHead_q;
      outTail_d  = outTail_q;
      outCount_d = outCount_q;
      overflow_d = overflow_q;

      if (inPush) inTail_d = inTail_q + PTR_ONE;
      if (inPop)  inHead_d = inHead_q + PTR_ONE;
      case ({inPush, inPop})
         2'b10:   inCount_d = inCount_q + CNT_ONE;
         2'b01:   inCount_d = inCount_q - CNT_ONE;
         default: inCount_d = inCount_q;
      endcase

      if (outPush) outTail_d = outTail_q + PTR_ONE;
      if (hostPop) outHead_d = outHead_q + PTR_ONE;
      case ({outPush, hostPop})
         2'b10:   outCount_d = outCount_q + CNT_ONE;
         2'b01:   outCount_d = outCount_q - CNT_ONE;
         default: outCount_d = outCount_q;
      endcase

      if (overflowSet) begin
         overflow_d = 1'b1;
      end else if (overflowClr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inHead_q   <= '0;
         inTail_q   <= '0;
         inCount_q  <= '0;
         outHead_q  <= '0;
         outTail_q  <= '0;
         outCount_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         inHead_q   <= inHead_d;
         inTail_q   <= inTail_d;
         inCount_q  <= inCount_d;
         outHead_q  <= outHead_d;
         outTail_q  <= outTail_d;
         outCount_q <= outCount_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.ReadData   = readData_q;
   assign bus.ioInFull   = inFull;
   assign bus.ioOutValid = outValid;
   assign bus.ioOutData  = outValid ? outBuf_q[outHead_q] : 8'h00;
endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Byte-wide responder for the RAM port driven by the memory controller. It answers every cycle's `RWstate`/`RWaddr`/`WrtData` request with a one-cycle-latency `ReadData` byte. The address space is split into two regions:
- Addresses with `RWaddr[17:16] != 2'b11` go to a synchronous byte RAM.
- Addresses with `RWaddr[17:16] == 2'b11` go to a small memory-mapped I/O block with input and output byte FIFOs toward the host/testbench.

The block is the simulation and FPGA-side counterpart of the controller's RAM interface.

## Interface
- `ADDR_WIDTH`, 17: RAM holds 2^ADDR_WIDTH bytes, indexed by `RWaddr[ADDR_WIDTH-1:0]`.
- `FIFO_DEPTH`, 8: depth of each I/O FIFO in bytes; must be a power of two, ≥2.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rdy`  in  1: global ready; while low the block holds all state.
- `RWstate`  in  1: 0 = read, 1 = write (this cycle's request).
- `RWaddr`  in  32: byte address.
- `WrtData`  in  8: write byte.
- `ReadData`  out  8: registered read byte for the previous cycle's address.
- `ioInEn`  in  1: host pushes `ioInData` into the input FIFO.
- `ioInData`  in  8: host input byte.
- `ioInFull`  out  1: input FIFO full; the host must not push.
- `ioOutValid`  out  1: output FIFO non-empty.
- `ioOutData`  out  8: output FIFO head byte.
- `ioOutReady`  in  1: host consumes the head byte when `ioOutValid` is high.

## Operation
- Every cycle with `rdy` high is a request, and the address is decoded every cycle.
- RAM region:
  - Write stores `WrtData` at the indexed byte.
  - Read registers the stored byte into `ReadData`.
  - `RWaddr[31:18]` and the bits between `ADDR_WIDTH` and 16 are ignored (aliasing is allowed).
  - RAM contents are not cleared by reset; they are preloadable by simulation.
- I/O region (decode uses the full `RWaddr[17:0]`; exact-match only):
  - `0x30000` read: if the input FIFO is non-empty, return its head and pop it; if empty, return `0x00` with no pop.
  - `0x30000` write: push `WrtData` into the output FIFO. If the FIFO is full and no host pop happens that cycle, drop the byte and set the sticky `overflow` flag.
  - `0x30004` read: returns `{5'b0, overflow, outFull, inNonEmpty}`.
  - `0x30004` write: clears `overflow`; data is ignored.
  - Any other I/O address: read returns `0x00`; writes are ignored with no side effects.
  - Exact-match decode guarantees that the controller's trailing byte cycles (`0x30001..0x30004` during a multi-byte or overrunning access) never pop or push twice. The one exception is that a word access at `0x30000` also reads or writes `0x30004`.
- Input FIFO:
  - Push on `ioInEn & !ioInFull & rdy`.
  - `ioInEn` while full is ignored.
  - A push and a bus pop in the same cycle are both performed.
- Output FIFO:
  - Host pop on `ioOutValid & ioOutReady & rdy`.
  - A simultaneous bus push and host pop when full is accepted, and the count is unchanged.
- Both FIFOs are circular buffers with a `log2(FIFO_DEPTH)`-bit head/tail that wraps modulo depth, plus a `log2(FIFO_DEPTH)+1`-bit count.
- Flag definitions:
  - `ioInFull = (inCount == FIFO_DEPTH)`.
  - `outFull = (outCount == FIFO_DEPTH)`.
  - `inNonEmpty = (inCount != 0)`.
  - `ioOutValid = (outCount != 0)`; `ioOutData` is the head entry, combinational from registers.

## Timing
- Read latency is 1: the address presented in cycle t yields `ReadData` valid after edge t, for use in cycle t+1. This matches the controller capturing byte k at stage k+1.
- A write updates the RAM or FIFO at edge t. A read of the same address in cycle t+1 returns the new value.
- During a write cycle, `ReadData` holds its previous value.
- `rdy` low:
  - no RAM write and no FIFO push/pop;
  - `overflow` unchanged;
  - `ReadData` held;
  - host handshakes are not honored.
- Reset values (next edge with `rst` high, regardless of `rdy`):
  - `ReadData = 0x00`.
  - Both FIFOs empty, so `ioInFull = 0`, `ioOutValid = 0`, `ioOutData = 0x00`.
  - `overflow = 0`.
- A reset that lands mid-access abandons the access. Bytes in flight in the FIFOs are discarded.

## Test plan
- Read/write RAM:
  - Write `0xA5` to `0x00010`, then read `0x00010` the next cycle → `ReadData = 0xA5` one cycle after the read address.
  - Read 4 consecutive bytes `0x100..0x103` preloaded `11 22 33 44` → `ReadData` sequence `11,22,33,44` with 1-cycle lag.
- Output FIFO:
  - Host `ioOutReady = 0`; 9 writes to `0x30000` (`0x01..0x09`, `FIFO_DEPTH` = 8) → 8 bytes stored, `0x09` dropped, status read of `0x30004` = `0x06`.
  - Host drains → `ioOutData` order `01..08`.
- Input FIFO:
  - Host pushes `0x41, 0x42`; bus reads `0x30000`, `0x30001`, `0x30000`, `0x30000` → `ReadData` `41, 00, 42, 00`; `inNonEmpty` clears after the second pop.
- Full boundary: output FIFO full, bus write and host pop in the same cycle → byte accepted, count stays 8, `overflow` stays 0.
- `rdy` / reset:
  - Hold `rdy = 0` during a write to `0x30000` and an `ioInEn` pulse → no FIFO change.
  - Assert `rst` with both FIFOs partly filled → next cycle `ioOutValid = 0`, status read = `0x00`.
